// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, EX forwarding and dmem wait-state FSM.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ID_rs1_i,
    input  logic [REG_AW-1:0] ID_rs2_i,
    input  logic [REG_AW-1:0] EX_rs1_i,
    input  logic [REG_AW-1:0] EX_rs2_i,
    input  logic [REG_AW-1:0] EX_rd_i,
    input  logic              EX_MemRead_i,
    input  logic              EX_pc_sel_i,
    input  logic [REG_AW-1:0] MEM_rd_i,
    input  logic              MEM_RegWrite_i,
    input  logic              MEM_req_i,
    input  logic [REG_AW-1:0] WB_rd_i,
    input  logic              WB_RegWrite_i,
    input  logic              dmem_gnt_i,
    output logic              dmem_req_o,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              ex_mem_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              mem_wb_flush_o,
    output logic [1:0]        forwardA_o,
    output logic [1:0]        forwardB_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic              mem_err_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic mem_stall;
    logic load_use;
    logic branch_flush;
    logic lu_stall;

    // Every hazard term is gated by rst_n so outputs show reset values while reset is held.
    always_comb begin
        mem_stall = 1'b0;
        if (rst_n) begin
            if (state_q == StErr) begin
                mem_stall = 1'b1;
            end else begin
                mem_stall = MEM_req_i & ~dmem_gnt_i;
            end
        end
    end

    assign load_use     = rst_n & EX_MemRead_i & (EX_rd_i != '0) &
                          ((EX_rd_i == ID_rs1_i) | (EX_rd_i == ID_rs2_i));
    assign branch_flush = rst_n & EX_pc_sel_i & ~mem_stall;
    assign lu_stall     = load_use & ~mem_stall & ~EX_pc_sel_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            StIdle: begin
                if (MEM_req_i && !dmem_gnt_i) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StWait: begin
                if (dmem_gnt_i) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
                    state_d   = StErr;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        dmem_req_o     = rst_n & MEM_req_i & (state_q != StErr);
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (mem_stall) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
        end else if (branch_flush) begin
            // ID holds a wrong-path instruction, so any load-use stall is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    assign mem_err_o = mem_err_q;

    // Forwarding: MEM result is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        forwardA_o = 2'b00;
        forwardB_o = 2'b00;
        if (rst_n) begin
            if (MEM_RegWrite_i && (MEM_rd_i != '0) && (MEM_rd_i == EX_rs1_i)) begin
                forwardA_o = 2'b01;
            end else if (WB_RegWrite_i && (WB_rd_i != '0) && (WB_rd_i == EX_rs1_i)) begin
                forwardA_o = 2'b10;
            end
            if (MEM_RegWrite_i && (MEM_rd_i != '0) && (MEM_rd_i == EX_rs2_i)) begin
                forwardB_o = 2'b01;
            end else if (WB_RegWrite_i && (WB_rd_i != '0) && (WB_rd_i == EX_rs2_i)) begin
                forwardB_o = 2'b10;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != StErr) begin
            if ((mem_stall || lu_stall) && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational vectors plus dmem stall,
// timeout and asynchronous-reset sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_rs1_i, ID_rs2_i, EX_rs1_i, EX_rs2_i, EX_rd_i, MEM_rd_i, WB_rd_i;
    logic       EX_MemRead_i, EX_pc_sel_i, MEM_RegWrite_i, MEM_req_i, WB_RegWrite_i;
    logic       dmem_gnt_i;
    logic       dmem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
    logic       if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, mem_err_o;
    logic [1:0] forwardA_o, forwardB_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_rs1_i       (ID_rs1_i),
        .ID_rs2_i       (ID_rs2_i),
        .EX_rs1_i       (EX_rs1_i),
        .EX_rs2_i       (EX_rs2_i),
        .EX_rd_i        (EX_rd_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_pc_sel_i    (EX_pc_sel_i),
        .MEM_rd_i       (MEM_rd_i),
        .MEM_RegWrite_i (MEM_RegWrite_i),
        .MEM_req_i      (MEM_req_i),
        .WB_rd_i        (WB_rd_i),
        .WB_RegWrite_i  (WB_RegWrite_i),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_req_o     (dmem_req_o),
        .pc_en_o        (pc_en_o),
        .if_id_en_o     (if_id_en_o),
        .id_ex_en_o     (id_ex_en_o),
        .ex_mem_en_o    (ex_mem_en_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .mem_wb_flush_o (mem_wb_flush_o),
        .forwardA_o     (forwardA_o),
        .forwardB_o     (forwardB_o),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
`endif
        .mem_err_o      (mem_err_o)
    );

    // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
    //  forwardA, forwardB}
    logic [11:0] out_vec;
    always_comb begin
        out_vec = {dmem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, if_id_flush_o,
                   id_ex_flush_o, mem_wb_flush_o, forwardA_o, forwardB_o};
    end

    localparam logic [11:0] ExpNominal = 12'h780;
    localparam logic [11:0] ExpStall   = 12'h810;
    localparam logic [11:0] ExpFrozen  = 12'h010;

    typedef struct {
        string       name;
        logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
        logic        ex_memread, ex_pc_sel;
        logic [4:0]  mem_rd;
        logic        mem_rw, mem_req;
        logic [4:0]  wb_rd;
        logic        wb_rw, gnt;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input string n, input int id1, input int id2, input int e1, input int e2,
                       input int erd, input bit mr, input bit ps, input int mrd, input bit mrw,
                       input bit mreq, input int wrd, input bit wrw, input bit g,
                       input logic [11:0] e);
        vec_t v;
        v.name = n;
        v.id_rs1 = 5'(id1); v.id_rs2 = 5'(id2);
        v.ex_rs1 = 5'(e1);  v.ex_rs2 = 5'(e2);  v.ex_rd = 5'(erd);
        v.ex_memread = mr;  v.ex_pc_sel = ps;
        v.mem_rd = 5'(mrd); v.mem_rw = mrw;     v.mem_req = mreq;
        v.wb_rd = 5'(wrd);  v.wb_rw = wrw;      v.gnt = g;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        ID_rs1_i = v.id_rs1; ID_rs2_i = v.id_rs2;
        EX_rs1_i = v.ex_rs1; EX_rs2_i = v.ex_rs2; EX_rd_i = v.ex_rd;
        EX_MemRead_i = v.ex_memread; EX_pc_sel_i = v.ex_pc_sel;
        MEM_rd_i = v.mem_rd; MEM_RegWrite_i = v.mem_rw; MEM_req_i = v.mem_req;
        WB_rd_i = v.wb_rd; WB_RegWrite_i = v.wb_rw; dmem_gnt_i = v.gnt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{name: "", id_rs1: 0, id_rs2: 0, ex_rs1: 0, ex_rs2: 0, ex_rd: 0, ex_memread: 0,
              ex_pc_sel: 0, mem_rd: 0, mem_rw: 0, mem_req: 0, wb_rd: 0, wb_rw: 0, gnt: 0,
              exp: 0};
        drive(v);
    endtask

    // From IDLE with req and no grant: error appears after the 16th edge (IDLE + 15 waits).
    task automatic run_timeout(input string tag);
        MEM_req_i  = 1'b1;
        dmem_gnt_i = 1'b0;
        for (int n = 0; n <= 16; n++) begin
            #1;
            if (n >= 14) chk($sformatf("%s_err_n%0d", tag, n), 32'(mem_err_o), 32'(n == 16));
            if (n < 16) @(negedge clk);
        end
        chk({tag, "_frozen"}, 32'(out_vec), 32'(ExpFrozen));
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        add("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ExpNominal);
        add("lu_rs1",      5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 12'h1A0);
        add("lu_rs2",      0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 12'h1A0);
        add("lu_x0",       0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, ExpNominal);
        add("no_load",     5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, ExpNominal);
        add("br_over_lu",  5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 12'h7E0);
        add("fwd_mem",     0, 0, 7, 7, 0, 0, 0, 7, 1, 0, 7, 1, 1, 12'h785);
        add("fwd_wb",      0, 0, 7, 7, 0, 0, 0, 7, 0, 0, 7, 1, 1, 12'h78A);
        add("fwd_x0",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, ExpNominal);
        add("fwd_mix",     0, 0, 3, 4, 0, 0, 0, 3, 1, 0, 4, 1, 1, 12'h786);
        add("req_gnt",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'hF80);
        add("stall_prio",  5, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 12'h810);
        add("release_br",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 12'hFE0);
        add("idle_again",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ExpNominal);

        // Hazard inputs active during reset must not leak to the outputs.
        #2;
        drive(vecs[11]);
        #1;
        chk("rst_outputs", 32'(out_vec), 32'(ExpNominal));
        chk("rst_err", 32'(mem_err_o), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk(vecs[i].name, 32'(out_vec), 32'(vecs[i].exp));
        end

        // Three grant-less cycles, then grant: exactly three stall cycles.
        @(negedge clk);
        idle_inputs();
        MEM_req_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall_c%0d", c), 32'(out_vec), 32'(ExpStall));
            @(negedge clk);
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("stall_release", 32'(out_vec), 32'(12'hF80));
        @(negedge clk);
        idle_inputs();
        #1;
        chk("stall_after", 32'(out_vec), 32'(ExpNominal));
        @(negedge clk);

        // Timeout from IDLE also proves the FSM returned to IDLE with a cleared counter.
        run_timeout("to1");
        @(negedge clk);
        MEM_req_i  = 1'b0;
        dmem_gnt_i = 1'b1;
        #1;
        chk("err_terminal", 32'(out_vec), 32'(ExpFrozen));
        chk("err_sticky", 32'(mem_err_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("err_rst_outputs", 32'(out_vec), 32'(ExpNominal));
        chk("err_rst_clear", 32'(mem_err_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Reset in the middle of a wait: immediate effect and a fresh timeout afterwards.
        @(negedge clk);
        MEM_req_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_outputs", 32'(out_vec), 32'(ExpNominal));
        chk("midwait_rst_err", 32'(mem_err_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        run_timeout("to2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
